// File: rtl/prf_pkg.sv
// Shared constants and types for the physical register file.
// Optional feature macro: PRF_BYPASS_EN (same-cycle write-to-read forwarding).
package prf_pkg;

  localparam int PRF_DATA_WIDTH = 32;
  localparam int PRF_DEPTH      = 64;
  localparam int PRF_AW         = $clog2(PRF_DEPTH);

  typedef logic [PRF_AW-1:0]         prf_addr_t;
  typedef logic [PRF_DATA_WIDTH-1:0] prf_data_t;

endpackage

// File: rtl/prf_read_port.sv
// One combinational read port of the physical register file: addressed mux
// over storage and ready vector, enable gating, optional same-cycle write
// forwarding when PRF_BYPASS_EN is defined.
module prf_read_port
  import prf_pkg::*;
#(
  parameter int  DATA_WIDTH = PRF_DATA_WIDTH,
  parameter int  DEPTH      = PRF_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0]      ready,
`ifdef PRF_BYPASS_EN
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  input  logic                  wr2_en,
  input  logic [AW-1:0]         wr2_addr,
  input  logic [DATA_WIDTH-1:0] wr2_data,
`endif
  output logic [DATA_WIDTH-1:0] data,
  output logic                  rdy
);

`ifdef PRF_BYPASS_EN
  logic hit1;
  logic hit2;

  // Forwarding matches; entry 0 never forwards since writes to it are dropped.
  always_comb begin
    hit1 = wr1_en && (wr1_addr == addr) && (addr != {AW{1'b0}});
    hit2 = wr2_en && (wr2_addr == addr) && (addr != {AW{1'b0}});
  end

  // Select forwarded write data (port 1 first) or registered state, gated by enable.
  always_comb begin
    data = {DATA_WIDTH{1'b0}};
    rdy  = 1'b0;
    if (!en) begin
      data = {DATA_WIDTH{1'b0}};
      rdy  = 1'b0;
    end else if (hit1) begin
      data = wr1_data;
      rdy  = 1'b1;
    end else if (hit2) begin
      data = wr2_data;
      rdy  = 1'b1;
    end else begin
      data = mem[addr];
      rdy  = ready[addr];
    end
  end
`else
  // Registered-state read, gated by enable.
  always_comb begin
    data = {DATA_WIDTH{1'b0}};
    rdy  = 1'b0;
    if (en) begin
      data = mem[addr];
      rdy  = ready[addr];
    end else begin
      data = {DATA_WIDTH{1'b0}};
      rdy  = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/prf_regfile.sv
// Physical register file: 2 writeback ports, 2 rename-allocate ports,
// 4 combinational read ports, per-entry ready bits and a registered busy count.
// Entry 0 is hardwired to data 0 / ready 1.
// Optional feature macro: PRF_BYPASS_EN (reads see same-cycle writes).
module prf_regfile
  import prf_pkg::*;
#(
  parameter int  DATA_WIDTH = PRF_DATA_WIDTH,
  parameter int  DEPTH      = PRF_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr1_en_i,
  input  logic [AW-1:0]         wr1_addr_i,
  input  logic [DATA_WIDTH-1:0] wr1_data_i,
  input  logic                  wr2_en_i,
  input  logic [AW-1:0]         wr2_addr_i,
  input  logic [DATA_WIDTH-1:0] wr2_data_i,
  input  logic                  alloc1_en_i,
  input  logic [AW-1:0]         alloc1_addr_i,
  input  logic                  alloc2_en_i,
  input  logic [AW-1:0]         alloc2_addr_i,
  input  logic                  rd11_en_i,
  input  logic [AW-1:0]         rd11_addr_i,
  output logic [DATA_WIDTH-1:0] rd11_data_o,
  output logic                  rd11_rdy_o,
  input  logic                  rd12_en_i,
  input  logic [AW-1:0]         rd12_addr_i,
  output logic [DATA_WIDTH-1:0] rd12_data_o,
  output logic                  rd12_rdy_o,
  input  logic                  rd21_en_i,
  input  logic [AW-1:0]         rd21_addr_i,
  output logic [DATA_WIDTH-1:0] rd21_data_o,
  output logic                  rd21_rdy_o,
  input  logic                  rd22_en_i,
  input  logic [AW-1:0]         rd22_addr_i,
  output logic [DATA_WIDTH-1:0] rd22_data_o,
  output logic                  rd22_rdy_o,
  output logic [AW:0]           busy_cnt_o
);

  localparam int NRD = 4;

  logic [DATA_WIDTH-1:0] mem      [DEPTH];
  logic [DATA_WIDTH-1:0] mem_next [DEPTH];
  logic [DEPTH-1:0]      ready;
  logic [DEPTH-1:0]      ready_next;
  logic [AW:0]           busy_cnt;

  logic                  rd_en   [NRD];
  logic [AW-1:0]         rd_addr [NRD];
  logic [DATA_WIDTH-1:0] rd_data [NRD];
  logic                  rd_rdy  [NRD];

  // Number of entries whose ready bit is clear.
  function automatic logic [AW:0] count_busy(input logic [DEPTH-1:0] rdy_vec);
    logic [AW:0] cnt;
    cnt = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{AW{1'b0}}, ~rdy_vec[i]};
    end
    return cnt;
  endfunction

  // Next-state storage and ready vector: port 1 beats port 2 on data,
  // allocation beats writeback on ready, entry 0 never changes.
  always_comb begin
    mem_next[0]   = {DATA_WIDTH{1'b0}};
    ready_next[0] = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      logic w1, w2, a1, a2;
      w1 = wr1_en_i    && (wr1_addr_i    == AW'(i));
      w2 = wr2_en_i    && (wr2_addr_i    == AW'(i));
      a1 = alloc1_en_i && (alloc1_addr_i == AW'(i));
      a2 = alloc2_en_i && (alloc2_addr_i == AW'(i));
      mem_next[i]   = w1 ? wr1_data_i : (w2 ? wr2_data_i : mem[i]);
      ready_next[i] = (a1 || a2) ? 1'b0 : ((w1 || w2) ? 1'b1 : ready[i]);
    end
  end

  // State update; reset drops anything requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_WIDTH{1'b0}};
      end
      ready    <= {DEPTH{1'b1}};
      busy_cnt <= {(AW+1){1'b0}};
    end else begin
      mem      <= mem_next;
      ready    <= ready_next;
      busy_cnt <= count_busy(ready_next);
    end
  end

  assign busy_cnt_o = busy_cnt;

  // Gather the four read ports into arrays for the generate loop.
  always_comb begin
    rd_en[0]   = rd11_en_i;
    rd_addr[0] = rd11_addr_i;
    rd_en[1]   = rd12_en_i;
    rd_addr[1] = rd12_addr_i;
    rd_en[2]   = rd21_en_i;
    rd_addr[2] = rd21_addr_i;
    rd_en[3]   = rd22_en_i;
    rd_addr[3] = rd22_addr_i;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    prf_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_rd (
      .en      (rd_en[p]),
      .addr    (rd_addr[p]),
      .mem     (mem),
      .ready   (ready),
`ifdef PRF_BYPASS_EN
      .wr1_en  (wr1_en_i),
      .wr1_addr(wr1_addr_i),
      .wr1_data(wr1_data_i),
      .wr2_en  (wr2_en_i),
      .wr2_addr(wr2_addr_i),
      .wr2_data(wr2_data_i),
`endif
      .data    (rd_data[p]),
      .rdy     (rd_rdy[p])
    );
  end

  assign rd11_data_o = rd_data[0];
  assign rd11_rdy_o  = rd_rdy[0];
  assign rd12_data_o = rd_data[1];
  assign rd12_rdy_o  = rd_rdy[1];
  assign rd21_data_o = rd_data[2];
  assign rd21_rdy_o  = rd_rdy[2];
  assign rd22_data_o = rd_data[3];
  assign rd22_rdy_o  = rd_rdy[3];

endmodule

// File: tb/tb_prf_regfile.sv
// Scoreboard bench for prf_regfile: stimulus pushes expected read/busy values,
// a negedge monitor pops and compares them.
module tb_prf_regfile;
  import prf_pkg::*;

  typedef struct {
    prf_data_t data;
    logic      rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr1_en = 1'b0, wr2_en = 1'b0, alloc1_en = 1'b0, alloc2_en = 1'b0;
  prf_addr_t wr1_addr = '0, wr2_addr = '0, alloc1_addr = '0, alloc2_addr = '0;
  prf_data_t wr1_data = '0, wr2_data = '0;
  logic      rd_en   [4];
  prf_addr_t rd_addr [4];
  prf_data_t rd_data [4];
  logic      rd_rdy  [4];
  logic [PRF_AW:0] busy_cnt;

  exp_t            rq[$];
  logic [PRF_AW:0] bq[$];
  logic            chk_busy = 1'b0;
  int checks = 0;
  int errors = 0;

  prf_regfile dut (
    .clk(clk), .rst(rst),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .wr2_en_i(wr2_en), .wr2_addr_i(wr2_addr), .wr2_data_i(wr2_data),
    .alloc1_en_i(alloc1_en), .alloc1_addr_i(alloc1_addr),
    .alloc2_en_i(alloc2_en), .alloc2_addr_i(alloc2_addr),
    .rd11_en_i(rd_en[0]), .rd11_addr_i(rd_addr[0]), .rd11_data_o(rd_data[0]), .rd11_rdy_o(rd_rdy[0]),
    .rd12_en_i(rd_en[1]), .rd12_addr_i(rd_addr[1]), .rd12_data_o(rd_data[1]), .rd12_rdy_o(rd_rdy[1]),
    .rd21_en_i(rd_en[2]), .rd21_addr_i(rd_addr[2]), .rd21_data_o(rd_data[2]), .rd21_rdy_o(rd_rdy[2]),
    .rd22_en_i(rd_en[3]), .rd22_addr_i(rd_addr[3]), .rd22_data_o(rd_data[3]), .rd22_rdy_o(rd_rdy[3]),
    .busy_cnt_o(busy_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare every enabled read port in port order, disabled ports against 0/0.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_en[p]) begin
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL rd%0d_underflow: no expected entry, got data=%h rdy=%b", p, rd_data[p], rd_rdy[p]);
          end else begin
            exp_t e;
            e = rq.pop_front();
            if (rd_data[p] !== e.data || rd_rdy[p] !== e.rdy) begin
              errors++;
              $display("FAIL rd%0d addr=%0d: got data=%h rdy=%b, want data=%h rdy=%b",
                       p, rd_addr[p], rd_data[p], rd_rdy[p], e.data, e.rdy);
            end
          end
        end else if (rd_data[p] !== '0 || rd_rdy[p] !== 1'b0) begin
          errors++;
          $display("FAIL rd%0d_disabled: got data=%h rdy=%b, want 0/0", p, rd_data[p], rd_rdy[p]);
        end
      end
      if (chk_busy) begin
        logic [PRF_AW:0] eb;
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL busy_underflow: got %0d, no expected value", busy_cnt);
        end else begin
          eb = bq.pop_front();
          if (busy_cnt !== eb) begin
            errors++;
            $display("FAIL busy_cnt: got %0d, want %0d", busy_cnt, eb);
          end
        end
      end
    end
  end

  task automatic rd(input int p, input int a, input logic [31:0] d, input logic r);
    exp_t e;
    rd_en[p]   = 1'b1;
    rd_addr[p] = prf_addr_t'(a);
    e.data = d;
    e.rdy  = r;
    rq.push_back(e);
  endtask

  task automatic busy(input int n);
    chk_busy = 1'b1;
    bq.push_back((PRF_AW+1)'(n));
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    if (port == 1) begin
      wr1_en = 1'b1; wr1_addr = prf_addr_t'(a); wr1_data = d;
    end else begin
      wr2_en = 1'b1; wr2_addr = prf_addr_t'(a); wr2_data = d;
    end
  endtask

  task automatic alloc(input int port, input int a);
    if (port == 1) begin
      alloc1_en = 1'b1; alloc1_addr = prf_addr_t'(a);
    end else begin
      alloc2_en = 1'b1; alloc2_addr = prf_addr_t'(a);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    wr1_en = 1'b0; wr2_en = 1'b0; alloc1_en = 1'b0; alloc2_en = 1'b0;
    chk_busy = 1'b0;
    for (int p = 0; p < 4; p++) begin
      rd_en[p]   = 1'b0;
      rd_addr[p] = '0;
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      rd_en[p] = 1'b0;
      rd_addr[p] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state
    rd(0, 5, 32'h0, 1'b1); busy(0);
    tick();
    // 2: alloc then write
    alloc(1, 7);
    tick();
    rd(0, 7, 32'h0, 1'b0); busy(1);
    tick();
    wr(1, 7, 32'hDEADBEEF);
`ifdef PRF_BYPASS_EN
    rd(0, 7, 32'hDEADBEEF, 1'b1);
`else
    rd(0, 7, 32'h0, 1'b0);
`endif
    busy(1);
    tick();
    rd(0, 7, 32'hDEADBEEF, 1'b1); busy(0);
    tick();
    // 3: both write ports on one entry, port 1 wins
    wr(1, 9, 32'h11); wr(2, 9, 32'h22);
    tick();
    rd(1, 9, 32'h11, 1'b1); rd(3, 7, 32'hDEADBEEF, 1'b1); busy(0);
    tick();
    // 4: alloc and write same entry
    alloc(2, 12); wr(2, 12, 32'h55);
`ifdef PRF_BYPASS_EN
    rd(2, 12, 32'h55, 1'b1);
`else
    rd(2, 12, 32'h0, 1'b1);
`endif
    tick();
    rd(2, 12, 32'h55, 1'b0); busy(1);
    tick();
    // 5: read of an entry being written this cycle
    wr(1, 3, 32'hA5);
`ifdef PRF_BYPASS_EN
    rd(2, 3, 32'hA5, 1'b1);
`else
    rd(2, 3, 32'h0, 1'b1);
`endif
    tick();
    rd(2, 3, 32'hA5, 1'b1); busy(1);
    tick();
    // 6: entry 0 is hardwired
    wr(1, 0, 32'hFF); alloc(1, 0);
    rd(0, 0, 32'h0, 1'b1);
    tick();
    rd(0, 0, 32'h0, 1'b1); busy(1);
    tick();
    // dual alloc to one entry counts once
    alloc(1, 20); alloc(2, 20);
    tick();
    rd(0, 20, 32'h0, 1'b0); rd(1, 12, 32'h55, 1'b0); busy(2);
    tick();
    // writeback clears both
    wr(1, 12, 32'h66); wr(2, 20, 32'h77);
    tick();
    rd(0, 12, 32'h66, 1'b1); rd(1, 20, 32'h77, 1'b1); rd(2, 9, 32'h11, 1'b1); busy(0);
    tick();
    // reset mid-operation drops pending updates and clears state
    alloc(1, 30);
    tick();
    rd(0, 30, 32'h0, 1'b0); busy(1);
    tick();
    rst = 1'b1;
    wr(1, 5, 32'h99); alloc(1, 6);
    tick();
    rst = 1'b0;
    rd(0, 5, 32'h0, 1'b1); rd(1, 6, 32'h0, 1'b1); rd(2, 12, 32'h0, 1'b1); rd(3, 30, 32'h0, 1'b1);
    busy(0);
    tick();

    checks++;
    if (rq.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got rq=%0d bq=%0d left, want 0/0", rq.size(), bq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
